// File: rtl/count_run_arbiter.sv
// Round-robin arbiter/sequencer sharing one up-counter between two requesters.
// Each granted run counts 0..len-1, then pulses done to the winner for one cycle.
module count_run_arbiter #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy,
  output logic [WIDTH-1:0] cnt,
  output logic             half
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic             win_q, win_d;
  logic             rr_q, rr_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic             busy_q, busy_d;
  logic             half_q, half_d;

  logic             pick;
  logic [WIDTH-1:0] pick_len;

  // A lone request wins outright; a tie goes to the requester the rr pointer names.
  always_comb begin
    pick     = (req == 2'b11) ? rr_q : req[1];
    pick_len = pick ? len1 : len0;
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    rr_d    = rr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    done_d  = 2'b00;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        gnt_d = 2'b00;
        if (|req) begin
          win_d = pick;
          len_d = pick_len;
          if (pick_len != '0) begin
            state_d = StRun;
            gnt_d   = pick ? 2'b10 : 2'b01;
          end else begin
            state_d = StDone;
            done_d  = pick ? 2'b10 : 2'b01;
            rr_d    = ~pick;
          end
        end
      end
      StRun: begin
        if (!req[win_q]) begin
          // Abort: no done pulse, but fairness still hands priority over.
          state_d = StIdle;
          gnt_d   = 2'b00;
          cnt_d   = '0;
          rr_d    = ~win_q;
        end else if (cnt_q == len_q - WIDTH'(1)) begin
          state_d = StDone;
          gnt_d   = 2'b00;
          done_d  = win_q ? 2'b10 : 2'b01;
          rr_d    = ~win_q;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        gnt_d   = 2'b00;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        gnt_d   = 2'b00;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != StIdle);
    half_d = (state_d == StRun) && (cnt_d >= (len_d >> 1));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      win_q   <= 1'b0;
      rr_q    <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      busy_q  <= 1'b0;
      half_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      rr_q    <= rr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      half_q  <= half_d;
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = busy_q;
  assign cnt  = cnt_q;
  assign half = half_q;

  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!reset) $onehot0(gnt));
  a_done_no_gnt : assert property (@(posedge clk) disable iff (!reset) !((|done) && (|gnt)));

endmodule

// File: tb/tb_count_run_arbiter.sv
// Scoreboard bench for count_run_arbiter: expected runs are queued as requests are
// driven and retired against grant/done activity seen on the outputs.
module tb_count_run_arbiter;
  localparam int unsigned WIDTH = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req;
  logic [WIDTH-1:0] len0, len1;
  logic [1:0]       gnt, done;
  logic             busy, half;
  logic [WIDTH-1:0] cnt;

  count_run_arbiter #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .len0 (len0),
    .len1 (len1),
    .gnt  (gnt),
    .done (done),
    .busy (busy),
    .cnt  (cnt),
    .half (half)
  );

  always #5 clk = ~clk;

  typedef struct {
    int who;
    int len;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_done   = 0;
  int   rr_exp   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitor / scoreboard consumer
  bit         sb_on     = 1'b0;
  bit         rr_mode   = 1'b0;
  bit         seen_gnt  = 1'b0;
  bit         post_done = 1'b0;
  int         run_idx   = 0;
  int         gap       = 0;
  logic [1:0] gnt_prev  = 2'b00;

  always @(negedge clk) begin
    if (sb_on) begin
      check("gnt_onehot0", int'($onehot0(gnt)), 1);
      check("done_with_gnt", int'((|done) && (|gnt)), 0);
      if (post_done) begin
        check("idle_cnt", int'(cnt), 0);
        check("idle_busy", int'(busy), 0);
      end
      if (gnt != 2'b00) begin
        if (gnt_prev == 2'b00) begin
          run_idx = 0;
          if (rr_mode && seen_gnt) check("rr_gap", gap, 2);
          seen_gnt = 1'b1;
          if (exp_q.size() == 0) check("gnt_unexpected", int'(gnt), 0);
          else check("gnt_who", int'(gnt), 1 << exp_q[0].who);
        end else begin
          run_idx++;
        end
        check("busy_run", int'(busy), 1);
        check("cnt_run", int'(cnt), run_idx);
        if (exp_q.size() > 0)
          check("half", int'(half), (run_idx >= (exp_q[0].len >> 1)) ? 1 : 0);
        gap = 0;
      end else begin
        gap++;
        check("half_off", int'(half), 0);
      end
      if (done != 2'b00) begin
        n_done++;
        if (exp_q.size() == 0) begin
          check("done_unexpected", int'(done), 0);
        end else begin
          e_mon = exp_q.pop_front();
          check("done_who", int'(done), 1 << e_mon.who);
          check("done_cnt", int'(cnt), (e_mon.len == 0) ? 0 : e_mon.len - 1);
          check("busy_done", int'(busy), 1);
          if (e_mon.len == 0) check("zero_no_gnt", int'(gnt_prev), 0);
          else check("run_len", run_idx + 1, e_mon.len);
        end
      end
    end
    post_done = sb_on && (done != 2'b00);
    gnt_prev  = gnt;
  end

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (n_done < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (n_done < target) check("timeout_done", n_done, target);
  endtask

  task automatic wait_cnt(input int v, input int budget);
    int k = 0;
    bit hit = 1'b0;
    while (!hit && k < budget) begin
      @(negedge clk);
      #1;
      k++;
      if (int'(cnt) == v && gnt != 2'b00) hit = 1'b1;
    end
    if (!hit) check("timeout_cnt", int'(cnt), v);
  endtask

  task automatic push_run(input int who, input int len);
    exp_t e;
    e.who = who;
    e.len = len;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_gnt"}, int'(gnt), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_cnt"}, int'(cnt), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_half"}, int'(half), 0);
  endtask

  initial begin
    int target;
    reset = 1'b0;
    req   = 2'b11;
    len0  = 5'd4;
    len1  = 5'd4;

    // Reset held with both requests pending
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check_reset_outs("rst");
    end
    push_run(0, 4);
    sb_on = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_release_gnt", int'(gnt), 1);
    req = 2'b01;
    wait_done(1, 20);
    req = 2'b00;
    rr_exp = 1;
    repeat (3) @(negedge clk);

    // Single run, len 5
    len0 = 5'd5;
    push_run(0, 5);
    req = 2'b01;
    @(negedge clk);
    check("single_latency", int'(gnt), 1);
    wait_done(2, 20);
    req = 2'b00;
    rr_exp = 1;
    repeat (3) @(negedge clk);

    // Round-robin with both requests held
    len0 = 5'd3;
    len1 = 5'd2;
    for (int i = 0; i < 4; i++) push_run((rr_exp + i) % 2, ((rr_exp + i) % 2 == 0) ? 3 : 2);
    rr_mode  = 1'b1;
    seen_gnt = 1'b0;
    req = 2'b11;
    wait_done(6, 60);
    req = 2'b00;
    rr_exp = (rr_exp + 3) % 2 == 0 ? 1 : 0;
    rr_mode = 1'b0;
    repeat (3) @(negedge clk);

    // Zero-length request
    len1 = 5'd0;
    push_run(1, 0);
    req = 2'b10;
    @(negedge clk);
    #1;
    check("zero_done", int'(done), 2);
    check("zero_gnt", int'(gnt), 0);
    req = 2'b00;
    rr_exp = 0;
    repeat (3) @(negedge clk);
    check("zero_after_cnt", int'(cnt), 0);

    // Abort at cnt 4, pending requester 1 takes over
    len0 = 5'd10;
    len1 = 5'd3;
    push_run(0, 10);
    req = 2'b01;
    wait_cnt(4, 20);
    req = 2'b10;
    @(negedge clk);
    #1;
    check("abort_gnt", int'(gnt), 0);
    check("abort_cnt", int'(cnt), 0);
    check("abort_done", int'(done), 0);
    check("abort_busy", int'(busy), 0);
    void'(exp_q.pop_front());
    push_run(1, 3);
    @(negedge clk);
    #1;
    check("abort_next_gnt", int'(gnt), 2);
    target = n_done + 1;
    wait_done(target, 20);
    req = 2'b00;
    rr_exp = 0;
    repeat (3) @(negedge clk);

    // Short run moves pointer to 1, then reset mid-run must restore it to 0
    len0 = 5'd1;
    push_run(0, 1);
    req = 2'b01;
    target = n_done + 1;
    wait_done(target, 20);
    req = 2'b00;
    repeat (3) @(negedge clk);
    len0 = 5'd20;
    push_run(0, 20);
    req = 2'b01;
    wait_cnt(7, 30);
    sb_on = 1'b0;
    reset = 1'b0;
    req   = 2'b11;
    @(negedge clk);
    check_reset_outs("midrst");
    exp_q.delete();
    len0 = 5'd2;
    len1 = 5'd2;
    push_run(0, 2);
    sb_on = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_rr_gnt", int'(gnt), 1);
    req = 2'b01;
    target = n_done + 1;
    wait_done(target, 20);
    req = 2'b00;
    repeat (3) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/count_run_arbiter.md
# count_run_arbiter

Arbiter and sequencer that shares one WIDTH-bit up-counter between two requesters. Each requester asks for a timed run of a programmed length. The block grants the counter round-robin, counts the run, and returns a one-cycle done pulse to the winner. It sits in front of the counter/flag datapath and is the only agent that starts, stops and clears the count.

## Interface

Parameters:
- WIDTH, 5, width of the shared counter and the run-length inputs

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- reset  in  1  synchronous, active-low reset (reset==0 at a rising edge clears all state)
- req  in  2  per-requester run request; level, held until the matching done or abort
- len0  in  WIDTH  run length for requester 0, sampled in the grant cycle
- len1  in  WIDTH  run length for requester 1, sampled in the grant cycle
- gnt  out  2  one-hot grant; high for the whole run of the granted requester
- done  out  2  one-cycle completion pulse to the granted requester
- busy  out  1  high in LOAD-free states RUN and DONE
- cnt  out  WIDTH  current shared count value
- half  out  1  high while in RUN and cnt >= (latched len >> 1)

## Operation

- Reset values: state=IDLE, gnt=00, done=00, busy=0, cnt=0, half=0, rr pointer=0 (requester 0 preferred).
- States: IDLE, RUN, DONE.
- IDLE, no req: hold; cnt=0.
- IDLE, any req:
  - Pick the winner. A single request wins outright. If both request, the winner is the requester the rr pointer names.
  - Latch the winner id and its len.
  - If len != 0: go to RUN with cnt=0.
  - If len == 0: go straight to DONE with no counting.
- RUN:
  - cnt increments by 1 each cycle.
  - When cnt == len_latched-1, the next state is DONE.
  - cnt never exceeds len-1 and never wraps. len = 2^WIDTH-1 is the longest run.
- DONE:
  - done[winner]=1 for exactly one cycle; gnt=00.
  - cnt holds the final value.
  - rr pointer set to the other requester.
  - Next state IDLE, where cnt clears to 0.
- Abort: if req[winner] drops in RUN, the next state is IDLE.
  - No done pulse.
  - gnt and cnt clear.
  - The rr pointer still moves to the other requester.
- Changes to the non-winner's req, or to len0/len1, during RUN or DONE have no effect.
- Reset at any point, including mid-RUN, overrides everything: next cycle matches the reset values and no done pulse is issued.
- gnt is always one-hot or zero. done is never asserted with gnt.

## Timing

- Reference: req sampled high in IDLE at edge t.
- t+1: gnt high, busy=1, cnt=0.
- cycles t+1..t+len: cnt = 0..len-1.
- t+len+1: state DONE, done pulse, gnt=00, busy=1.
- t+len+2: IDLE, busy=0, cnt=0.
  - A pending request is sampled at this edge, so the next grant appears at t+len+3.
- len==0: DONE at t+1, done pulse at t+1, IDLE at t+2.
- Abort: req[winner] low sampled at edge u gives IDLE and gnt=00 at u+1.
- Grant-to-grant minimum gap: 2 cycles (DONE plus IDLE).

## Test plan

- Reset: hold reset=0 three cycles with req=11 → gnt=00, done=00, cnt=0, busy=0 throughout. Release → requester 0 granted on the next cycle.
- Single run: req=01, len0=5 → gnt=01 for 5 cycles with cnt 0,1,2,3,4. Then done=01 for one cycle, then IDLE with cnt=0. half high for cnt>=2.
- Round-robin: req=11 held, len0=3, len1=2 → grants alternate 01,10,01,… Each done goes only to the current winner. The gap between gnt falling and the next gnt rising is 2 cycles.
- Zero length: req=10, len1=0 → no gnt. done=10 exactly one cycle after the request is sampled. cnt stays 0.
- Abort: req=01, len0=10, drop req[0] when cnt=4 → next cycle gnt=00, cnt=0, no done. A pending req[1] is granted next.
- Reset mid-run: len0=20, assert reset=0 at cnt=7 → next cycle all outputs at reset values. No done pulse. rr pointer back to 0.
